// File: rtl/pipeline_hazard_scoreboard.sv
// Hazard detection and forwarding-select scoreboard for a STAGES-deep back end.
// Tracks in-flight writebacks, freezes ID on RAW hazards, and counts stall cycles.
module pipeline_hazard_scoreboard #(
    parameter int REG_ADDR_WIDTH = 4,
    parameter int STAGES         = 3,
    parameter int SEL_WIDTH      = 2,
    parameter int PERF_WIDTH     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enableForwarding,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_src1,
    input  logic [REG_ADDR_WIDTH-1:0] id_src2,
    input  logic                      id_has_src1,
    input  logic                      id_has_src2,
    input  logic [REG_ADDR_WIDTH-1:0] id_dst,
    input  logic                      id_wb_en,
    input  logic                      id_mem_read,
    input  logic                      flush,
    output logic                      hazard_detected,
    output logic [SEL_WIDTH-1:0]      exe_sel_src1,
    output logic [SEL_WIDTH-1:0]      exe_sel_src2,
    output logic [PERF_WIDTH-1:0]     stall_count
);

    // The WB slot can never hazard or forward, so only EXE..STAGES-2 are stored,
    // and only the EXE slot's load flag is ever consulted.
    localparam int unsigned TRACK = STAGES - 1;

    logic [TRACK-1:0]          slot_valid;
    logic [TRACK-1:0]          slot_wb_en;
    logic [REG_ADDR_WIDTH-1:0] slot_dst [TRACK];
    logic                      slot0_load;

    logic [TRACK-1:0]          match1;
    logic [TRACK-1:0]          match2;
    logic [SEL_WIDTH-1:0]      fwd_sel1;
    logic [SEL_WIDTH-1:0]      fwd_sel2;
    logic                      issue;

    always_comb begin
        match1 = '0;
        match2 = '0;
        for (int unsigned k = 0; k < TRACK; k++) begin
            match1[k] = id_valid && id_has_src1 && slot_valid[k] && slot_wb_en[k]
                        && (slot_dst[k] == id_src1);
            match2[k] = id_valid && id_has_src2 && slot_valid[k] && slot_wb_en[k]
                        && (slot_dst[k] == id_src2);
        end
    end

    always_comb begin
        if (enableForwarding)
            hazard_detected = slot0_load && (match1[0] || match2[0]);
        else
            hazard_detected = (|match1) || (|match2);
    end

    // Scan oldest to youngest so the youngest matching slot overwrites last.
    always_comb begin
        fwd_sel1 = '0;
        fwd_sel2 = '0;
        for (int unsigned k = TRACK; k > 0; k--) begin
            if (match1[k-1]) fwd_sel1 = SEL_WIDTH'(k);
            if (match2[k-1]) fwd_sel2 = SEL_WIDTH'(k);
        end
    end

    assign issue = id_valid && !flush && !hazard_detected;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid   <= '0;
            slot_wb_en   <= '0;
            slot0_load   <= 1'b0;
            exe_sel_src1 <= '0;
            exe_sel_src2 <= '0;
            stall_count  <= '0;
        end else begin
            for (int unsigned k = 1; k < TRACK; k++) begin
                slot_valid[k] <= slot_valid[k-1];
                slot_wb_en[k] <= slot_wb_en[k-1];
                slot_dst[k]   <= slot_dst[k-1];
            end
            slot_valid[0] <= issue;
            slot_wb_en[0] <= id_wb_en;
            slot_dst[0]   <= id_dst;
            slot0_load    <= id_mem_read;

            if (issue && enableForwarding) begin
                exe_sel_src1 <= fwd_sel1;
                exe_sel_src2 <= fwd_sel2;
            end else begin
                exe_sel_src1 <= '0;
                exe_sel_src2 <= '0;
            end

            if (hazard_detected && (stall_count != '1))
                stall_count <= stall_count + PERF_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_scoreboard.sv
// Self-checking bench: directed vector table, random run against an issue-time
// model, and a saturation/reset sequence on a deep, narrow-counter instance.
module tb_pipeline_hazard_scoreboard;

    localparam int ST = 3;

    logic        clk = 1'b0;
    logic        rst, fwd, idv, h1, h2, wb, ld, fl;
    logic [3:0]  s1, s2, dst;
    logic        haz;
    logic [1:0]  sel1, sel2;
    logic [15:0] cnt;

    logic        sr, sv, sh1;
    logic [3:0]  ss1, sdst;
    logic        shaz;
    logic [2:0]  ssel1, ssel2;
    logic [1:0]  scnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_scoreboard #(
        .REG_ADDR_WIDTH(4), .STAGES(ST), .SEL_WIDTH(2), .PERF_WIDTH(16)
    ) u_dut (
        .clk(clk), .rst(rst), .enableForwarding(fwd), .id_valid(idv),
        .id_src1(s1), .id_src2(s2), .id_has_src1(h1), .id_has_src2(h2),
        .id_dst(dst), .id_wb_en(wb), .id_mem_read(ld), .flush(fl),
        .hazard_detected(haz), .exe_sel_src1(sel1), .exe_sel_src2(sel2),
        .stall_count(cnt)
    );

    pipeline_hazard_scoreboard #(
        .REG_ADDR_WIDTH(4), .STAGES(8), .SEL_WIDTH(3), .PERF_WIDTH(2)
    ) u_sat (
        .clk(clk), .rst(sr), .enableForwarding(1'b0), .id_valid(sv),
        .id_src1(ss1), .id_src2(4'd0), .id_has_src1(sh1), .id_has_src2(1'b0),
        .id_dst(sdst), .id_wb_en(1'b1), .id_mem_read(1'b0), .flush(1'b0),
        .hazard_detected(shaz), .exe_sel_src1(ssel1), .exe_sel_src2(ssel2),
        .stall_count(scnt)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst, fwd, v;
        logic [3:0] s1;
        logic       h1;
        logic [3:0] s2;
        logic       h2;
        logic [3:0] d;
        logic       wb, ld, fl;
        logic       ehaz;
        int         es1, es2, ecnt;
    } vec_t;

    function automatic vec_t mk(logic r, logic f, logic v, logic [3:0] a, logic ha,
                                logic [3:0] b, logic hb, logic [3:0] d, logic w,
                                logic l, logic fl_, logic eh, int e1, int e2, int ec);
        vec_t t;
        t.rst = r; t.fwd = f; t.v = v; t.s1 = a; t.h1 = ha; t.s2 = b; t.h2 = hb;
        t.d = d; t.wb = w; t.ld = l; t.fl = fl_;
        t.ehaz = eh; t.es1 = e1; t.es2 = e2; t.ecnt = ec;
        return t;
    endfunction

    vec_t tbl[31];

    typedef struct {
        int         issue;
        logic [3:0] d;
        bit         wb, ld;
    } mrec_t;

    mrec_t mq[$];
    int    cyc;

    // Age k of an instruction issued at cycle t is cyc - t - 1; lowest k wins.
    function automatic int youngest(logic [3:0] src, logic has, bit load_only, int maxk);
        int best = -1;
        if (!has || !idv) return -1;
        foreach (mq[i]) begin
            int k = cyc - mq[i].issue - 1;
            if (k >= 0 && k <= maxk && mq[i].wb && mq[i].d == src
                && (!load_only || mq[i].ld))
                if (best < 0 || k < best) best = k;
        end
        return best;
    endfunction

    function automatic logic [3:0] pick_reg();
        int r = $urandom_range(0, 4);
        case (r)
            3: return 4'd15;
            4: return 4'd3;
            default: return 4'(r);
        endcase
    endfunction

    initial begin
        int m_sel1, m_sel2, m_cnt;

        rst = 1; fwd = 0; idv = 0; s1 = 0; s2 = 0; h1 = 0; h2 = 0;
        dst = 0; wb = 0; ld = 0; fl = 0;
        sr = 1; sv = 0; sh1 = 0; ss1 = 0; sdst = 0;

        //          rst fwd v  s1 h1 s2 h2 d  wb ld fl  haz s1 s2 cnt
        tbl[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0,   0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 1, 1, 1, 3, 1, 2, 1, 0, 0,   0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0);
        tbl[4]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        tbl[5]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        tbl[6]  = mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0,   0, 0, 0, 0);
        tbl[7]  = mk(0, 0, 1, 1, 1, 3, 1, 2, 1, 0, 0,   1, 0, 0, 0);
        tbl[8]  = mk(0, 0, 1, 1, 1, 3, 1, 2, 1, 0, 0,   1, 0, 0, 1);
        tbl[9]  = mk(0, 0, 1, 1, 1, 3, 1, 2, 1, 0, 0,   0, 0, 0, 2);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 2);
        tbl[11] = mk(0, 1, 1, 0, 0, 0, 0, 4, 1, 1, 0,   0, 0, 0, 2);
        tbl[12] = mk(0, 1, 1, 4, 1, 4, 1, 5, 1, 0, 0,   1, 0, 0, 2);
        tbl[13] = mk(0, 1, 1, 4, 1, 4, 1, 5, 1, 0, 0,   0, 0, 0, 3);
        tbl[14] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 2, 2, 3);
        tbl[15] = mk(0, 1, 1, 0, 0, 0, 0, 6, 1, 0, 0,   0, 0, 0, 3);
        tbl[16] = mk(0, 1, 1, 0, 0, 0, 0, 6, 1, 0, 0,   0, 0, 0, 3);
        tbl[17] = mk(0, 1, 1, 6, 1, 0, 0, 9, 1, 0, 0,   0, 0, 0, 3);
        tbl[18] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 3);
        tbl[19] = mk(0, 1, 1, 0, 0, 0, 0, 7, 1, 0, 1,   0, 0, 0, 3);
        tbl[20] = mk(0, 0, 1, 7, 1, 7, 1, 10, 1, 0, 0,  0, 0, 0, 3);
        tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 3);
        tbl[22] = mk(0, 0, 1, 0, 0, 0, 0, 15, 1, 0, 0,  0, 0, 0, 3);
        tbl[23] = mk(0, 0, 1, 0, 0, 15, 1, 11, 1, 0, 1, 1, 0, 0, 3);
        tbl[24] = mk(0, 0, 1, 0, 0, 15, 1, 11, 1, 0, 0, 1, 0, 0, 4);
        tbl[25] = mk(0, 0, 1, 0, 0, 15, 1, 11, 1, 0, 0, 0, 0, 0, 5);
        tbl[26] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 5);
        tbl[27] = mk(0, 1, 1, 0, 0, 0, 0, 8, 1, 0, 0,   0, 0, 0, 5);
        tbl[28] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 5);
        tbl[29] = mk(0, 0, 1, 8, 1, 0, 0, 12, 1, 0, 0,  0, 0, 0, 0);
        tbl[30] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            rst = tbl[i].rst; fwd = tbl[i].fwd; idv = tbl[i].v;
            s1 = tbl[i].s1; h1 = tbl[i].h1; s2 = tbl[i].s2; h2 = tbl[i].h2;
            dst = tbl[i].d; wb = tbl[i].wb; ld = tbl[i].ld; fl = tbl[i].fl;
            @(negedge clk);
            check($sformatf("row%0d hazard", i), int'(haz), int'(tbl[i].ehaz));
            check($sformatf("row%0d sel1", i), int'(sel1), tbl[i].es1);
            check($sformatf("row%0d sel2", i), int'(sel2), tbl[i].es2);
            check($sformatf("row%0d stall_count", i), int'(cnt), tbl[i].ecnt);
            @(posedge clk);
            #1;
        end

        // Random phase: reset once so the model starts from a known empty pipe.
        rst = 1; idv = 0; fl = 0;
        @(posedge clk);
        #1;
        mq.delete();
        cyc = 0; m_sel1 = 0; m_sel2 = 0; m_cnt = 0;

        for (int n = 0; n < 400; n++) begin
            int y1, y2, l1, l2;
            bit mh, iss;
            rst = ($urandom_range(0, 49) == 0);
            fwd = ($urandom_range(0, 2) != 0);
            idv = ($urandom_range(0, 3) != 0);
            s1 = pick_reg(); s2 = pick_reg(); dst = pick_reg();
            h1 = 1'($urandom_range(0, 1)); h2 = 1'($urandom_range(0, 1));
            wb = ($urandom_range(0, 3) != 0);
            ld = ($urandom_range(0, 2) == 0);
            fl = ($urandom_range(0, 7) == 0);

            y1 = youngest(s1, h1, 1'b0, ST - 2);
            y2 = youngest(s2, h2, 1'b0, ST - 2);
            l1 = youngest(s1, h1, 1'b1, 0);
            l2 = youngest(s2, h2, 1'b1, 0);
            mh = fwd ? (l1 >= 0 || l2 >= 0) : (y1 >= 0 || y2 >= 0);

            @(negedge clk);
            check($sformatf("rnd%0d hazard", n), int'(haz), int'(mh));
            check($sformatf("rnd%0d sel1", n), int'(sel1), m_sel1);
            check($sformatf("rnd%0d sel2", n), int'(sel2), m_sel2);
            check($sformatf("rnd%0d stall_count", n), int'(cnt), m_cnt);

            iss = !rst && !fl && !mh && idv;
            if (rst) begin
                mq.delete();
                m_sel1 = 0; m_sel2 = 0; m_cnt = 0;
            end else begin
                if (mh && m_cnt < 65535) m_cnt++;
                if (iss) mq.push_back('{issue: cyc, d: dst, wb: wb, ld: ld});
                m_sel1 = (iss && fwd) ? y1 + 1 : 0;
                m_sel2 = (iss && fwd) ? y2 + 1 : 0;
            end
            cyc++;
            for (int i = mq.size() - 1; i >= 0; i--)
                if (cyc - mq[i].issue - 1 >= ST) mq.delete(i);

            @(posedge clk);
            #1;
        end
        rst = 1; idv = 0;

        // Saturation on the deep instance: a stall-only hazard lasts STAGES-1 cycles.
        sr = 1;
        repeat (2) @(posedge clk);
        #1;
        sr = 0; sv = 1; sdst = 4'd1; sh1 = 0; ss1 = 0;
        @(posedge clk);
        #1;
        ss1 = 4'd1; sh1 = 1; sdst = 4'd2;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check($sformatf("sat%0d hazard", j), int'(shaz), 1);
            @(posedge clk);
            #1;
            check($sformatf("sat%0d stall_count", j), int'(scnt), (j + 1 > 3) ? 3 : j + 1);
        end
        sv = 0; sr = 1;
        @(negedge clk);
        check("sat reset-cycle hazard", int'(shaz), 0);
        @(posedge clk);
        #1;
        check("sat post-reset stall_count", int'(scnt), 0);
        check("sat post-reset sel1", int'(ssel1), 0);
        check("sat post-reset sel2", int'(ssel2), 0);
        sr = 0; sv = 1;
        @(negedge clk);
        check("sat post-reset hazard", int'(shaz), 0);
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_scoreboard.md
Name: pipeline_hazard_scoreboard

Overview:
- Parametrised successor to the fixed 5-stage hazard-detection and forwarding logic.
- Tracks every in-flight writeback in a STAGES-deep shadow pipeline (slot 0 = EXE, slot STAGES-1 = WB).
- Produces the ID-stage freeze, and registered forwarding selects for the instruction entering EXE.
- Supports a run-time forwarding enable and branch flush, and keeps a saturating stall counter.

Parameters:
- REG_ADDR_WIDTH, 4, register-file address width.
- STAGES, 3, tracked stages after ID (EXE..WB); legal range 2..8.
- SEL_WIDTH, 2, forwarding-select width; must be ≥ clog2(STAGES).
- PERF_WIDTH, 16, stall counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- enableForwarding  in  1  1 = forwarding mode, 0 = stall-only mode
- id_valid  in  1  ID holds a real instruction
- id_src1, id_src2  in  REG_ADDR_WIDTH  ID source registers
- id_has_src1, id_has_src2  in  1  source is actually read
- id_dst  in  REG_ADDR_WIDTH  ID destination
- id_wb_en  in  1  ID instruction writes back
- id_mem_read  in  1  ID instruction is a load
- flush  in  1  branch taken in EXE this cycle
- hazard_detected  out  1  freeze IF/ID (combinational)
- exe_sel_src1, exe_sel_src2  out  SEL_WIDTH  registered forwarding select for the EXE instruction
- stall_count  out  PERF_WIDTH  saturating count of hazard cycles

Behaviour:
- Slot state per stage k: valid, dst, wb_en, is_load.
  - A slot is a producer when valid & wb_en.
  - Slots shift every cycle, k → k+1; slot STAGES-1 retires. The back end never stalls.
- Slot 0 next value:
  - A bubble (valid=0) if rst, flush, hazard_detected, or !id_valid.
  - Otherwise {1, id_dst, id_wb_en, id_mem_read}.
- Source match: src_i matches slot k iff id_has_src_i & id_valid & slot k is a producer & slot.dst == src_i.
- Slot STAGES-1 is never a hazard and never a forward source. The register file writes before it reads in the same cycle.
- Stall-only mode (enableForwarding=0): hazard_detected = 1 if either source matches any slot 0..STAGES-2.
- Forwarding mode (enableForwarding=1): hazard_detected = 1 only if either source matches slot 0 with is_load=1 (load-use).
- hazard_detected is combinational from current inputs and slots. It is independent of flush; flush still forces a bubble.
- Forwarding selects, per source i:
  - Updated at the clock edge that loads a non-bubble into slot 0.
  - Value = k+1 for the youngest (lowest k) matching slot k in 0..STAGES-2; 0 if none.
  - Forced to 0 when enableForwarding=0.
  - Cleared to 0 when slot 0 receives a bubble.
  - Encoding for STAGES=3: 1 = forward from MEM, 2 = forward from WB.
- A load in slot k≥1 may be forwarded; only slot 0 loads stall.
- stall_count increments on every cycle with hazard_detected=1 and rst=0. It saturates at all-ones and does not wrap.
- Reset values: all slots invalid, exe_sel_src1/2=0, stall_count=0. hazard_detected=0 during reset because all slots are invalid.
- Reset asserted mid-operation empties the shadow pipeline on the next edge. Forward paths are not retained.
- Simultaneous flush and hazard: bubble inserted; stall_count still increments.
- Simultaneous match in several slots: the youngest slot wins.
- dst/src equality includes register 15. There is no register-0 special case.

Test Plan:
- ADD r1 issued, then SUB r2,r1,r3 next cycle, enableForwarding=1 → hazard_detected=0; one cycle later exe_sel_src1=1, exe_sel_src2=0.
- Same sequence with enableForwarding=0 → hazard_detected=1 for 2 cycles; SUB enters EXE on cycle 3 with sel=0; stall_count=2.
- LDR r4, then ADD r5,r4,r4, forwarding on → exactly 1 hazard cycle; then exe_sel_src1=exe_sel_src2=2 (WB); stall_count=1.
- Two writers: r6 issued at T0 and T1, reader of r6 at T2 → exe_sel_src1=1 (youngest, MEM), not 2.
- flush=1 while ID holds a valid writer of r7, then a reader of r7 follows → no hazard from r7; sel=0; the slot stayed a bubble.
- PERF_WIDTH=2, persistent stall-only hazard for 6 cycles → stall_count 1,2,3,3,3,3. Then rst for one cycle → stall_count=0, hazard_detected=0, sels=0.
